lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side counterpart of the 5-bit LFSR random generator: checks a stream of 5-bit pseudo-random words against the same polynomial.
- Self-synchronises to the stream, then flywheels its own prediction and counts mismatching words.
- Presents the error count as two BCD digits (ones/tens) for the board display path.
- Sits between the generator output (or a link carrying it) and the display logic.

Parameters:
- LOCK_CNT, 3, consecutive correctly predicted words needed in SEARCH to declare lock (1..7)
- MISS_MAX, 4, consecutive mismatches in LOCKED that force a return to SEARCH (1..7)

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  asynchronous active-low reset
- rd_in  input  5  received pseudo-random word
- in_valid  input  1  rd_in is sampled on the posedge where in_valid=1
- clr_err  input  1  synchronous clear of the error count
- locked  output  1  1 = checker in LOCKED state
- err_ones  output  4  BCD ones digit of error count
- err_tens  output  4  BCD tens digit of error count

Behaviour:
- Polynomial (fixed): next(q) = {q[3:0], q[4]^q[2]}. The all-zero word is illegal; it never matches.
- Reset (rst=0, async): state=SEARCH, pred=0, seeded=0, match_cnt=0, miss_cnt=0, locked=0, err_ones=0, err_tens=0.
- All outputs are registered; an effect of a word sampled at edge N is visible after edge N.
- Cycles with in_valid=0 change no state except clr_err handling.
- SEARCH, on valid word w:
  - pred <= next(w).
  - If seeded=1, w!=0 and w==pred: match_cnt++. Reaching LOCK_CNT sets state=LOCKED and locked=1 on the same edge.
  - Otherwise match_cnt <= 0.
  - seeded <= (w!=0).
  - No errors are counted in SEARCH.
- LOCKED, on valid word w (flywheel; no reseeding):
  - pred <= next(pred).
  - w==pred: miss_cnt <= 0.
  - w!=pred: error count +1 and miss_cnt++. If miss_cnt reaches MISS_MAX, go to SEARCH on that edge: locked=0, match_cnt=0, seeded=0, miss_cnt=0. The error from that word is still counted.
- Error count:
  - Kept directly in BCD (tens:ones), 00..99.
  - ones wraps 9->0 with tens increment.
  - Saturates at 99; further errors are ignored.
- clr_err=1: count <= 00 on that edge. If an error occurs on the same edge, clear wins (result 00). clr_err does not affect state, locked, pred, or the miss/match counters.
- Reset asserted mid-operation returns everything to reset values immediately, regardless of clk.

Optional Feature:
- Macro: LFSR_CHK_SEG_EN.
- Defined: adds outputs seg_ones[6:0] and seg_tens[6:0]. These are active-low 7-segment encodings (bit order gfedcba) of err_ones/err_tens, registered one cycle after the BCD digits. Reset value is 7'b1000000 ("0").
- Undefined: these ports and their registers do not exist; the BCD outputs are unchanged.

Test Plan:
- Reset: hold rst=0 with random rd_in/in_valid -> locked=0, err_tens:err_ones=0:0. Release; idle with in_valid=0 for 10 cycles -> outputs unchanged.
- Acquire: valid words 00001, 00010, 00100, 01001 on consecutive edges -> locked=0 after edges 1-3, locked=1 after edge 4, count 00.
- Single error: after lock, send 10011 (expected 10010), then 00101 -> count 01 after the bad word, locked stays 1. Flywheel continues: next expected word is 01011.
- Loss of lock: after lock, send 4 consecutive wrong words -> count 04, locked falls after the 4th edge. Next word 00001 then reseeds the search.
- Zero word: in SEARCH, send 00000, then 00000, then the valid chain 00001, 00010, 00100, 01001 -> no lock from the zeros; lock only after the chain completes.
- Saturation/clear: force 105 errors in LOCKED -> count reads 99. Assert clr_err on the same edge as an error -> count 00. Assert rst mid-lock -> locked=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 5-bit LFSR stream: self-synchronises, flywheels, counts errors in BCD.
// Optional macro LFSR_CHK_SEG_EN adds registered active-low 7-segment outputs (gfedcba).
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned MISS_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rd_in,
  input  logic       in_valid,
  input  logic       clr_err,
  output logic       locked,
  output logic [3:0] err_ones,
  output logic [3:0] err_tens
`ifdef LFSR_CHK_SEG_EN
  ,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_tens
`endif
);

  localparam int unsigned W  = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned DW = 4;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    pred_q, pred_d;
  logic            seeded_q, seeded_d;
  logic [CW-1:0]   match_q, match_d;
  logic [CW-1:0]   miss_q, miss_d;
  logic [CW-1:0]   match_inc, miss_inc;
  logic            locked_d;
  logic [DW-1:0]   ones_d, tens_d;
  logic            err_inc;
  logic            word_nz;

  assign match_inc = match_q + CW'(1);
  assign miss_inc  = miss_q + CW'(1);
  assign word_nz   = (rd_in != '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEARCH;
      pred_q   <= '0;
      seeded_q <= 1'b0;
      match_q  <= '0;
      miss_q   <= '0;
      locked   <= 1'b0;
      err_ones <= '0;
      err_tens <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      seeded_q <= seeded_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked   <= locked_d;
      err_ones <= ones_d;
      err_tens <= tens_d;
    end
  end

  // Next-state, prediction, counters and BCD error count
  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    seeded_d = seeded_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_inc  = 1'b0;
    ones_d   = err_ones;
    tens_d   = err_tens;

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          pred_d   = lfsr_next(rd_in);
          seeded_d = word_nz;
          if (seeded_q && word_nz && (rd_in == pred_q)) begin
            if (match_inc == CW'(LOCK_CNT)) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from itself, never from the received word
          pred_d = lfsr_next(pred_q);
          if (rd_in == pred_q) begin
            miss_d = '0;
          end else begin
            err_inc = 1'b1;
            if (miss_inc == CW'(MISS_MAX)) begin
              state_d  = SEARCH;
              seeded_d = 1'b0;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);

    // Clear has priority over a coincident error; count saturates at 99
    if (clr_err) begin
      ones_d = '0;
      tens_d = '0;
    end else if (err_inc && !((err_tens == DW'(9)) && (err_ones == DW'(9)))) begin
      if (err_ones == DW'(9)) begin
        ones_d = '0;
        tens_d = err_tens + DW'(1);
      end else begin
        ones_d = err_ones + DW'(1);
      end
    end
  end

`ifdef LFSR_CHK_SEG_EN
  function automatic logic [6:0] seg7(input logic [DW-1:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Display encoding lags the BCD digits by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_ones <= 7'b1000000;
      seg_tens <= 7'b1000000;
    end else begin
      seg_ones <= seg7(err_ones);
      seg_tens <= seg7(err_tens);
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus randomized stream against a behavioural model.
// Define LFSR_CHK_SEG_EN to also check the 7-segment outputs.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 3;
  localparam int MISS_MAX = 4;

  logic       clk;
  logic       rst;
  logic [4:0] rd_in;
  logic       in_valid;
  logic       clr_err;
  logic       locked;
  logic [3:0] err_ones;
  logic [3:0] err_tens;
`ifdef LFSR_CHK_SEG_EN
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
`endif

  int checks = 0;
  int errors = 0;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_in    (rd_in),
    .in_valid (in_valid),
    .clr_err  (clr_err),
    .locked   (locked),
    .err_ones (err_ones),
    .err_tens (err_tens)
`ifdef LFSR_CHK_SEG_EN
    ,
    .seg_ones (seg_ones),
    .seg_tens (seg_tens)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: integer error count, lock/miss bookkeeping from the stream rules
  bit m_locked;
  bit m_seeded;
  int m_pred, m_match, m_miss, m_cnt, m_prev;

  function automatic int nxt(input int q);
    return ((q << 1) & 31) | (((q >> 4) ^ (q >> 2)) & 1);
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_pred = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic model_edge(input int w, input bit v, input bit c);
    bit err;
    err    = 0;
    m_prev = m_cnt;
    if (v) begin
      if (!m_locked) begin
        if (m_seeded && w != 0 && w == m_pred) begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_locked = 1; m_match = 0; end
        end else m_match = 0;
        m_pred   = nxt(w);
        m_seeded = (w != 0);
      end else begin
        err    = (w != m_pred);
        m_pred = nxt(m_pred);
        if (!err) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == MISS_MAX) begin m_locked = 0; m_seeded = 0; m_match = 0; m_miss = 0; end
        end
      end
    end
    if (c) m_cnt = 0;
    else if (err) m_cnt = (m_cnt >= 99) ? 99 : m_cnt + 1;
  endtask

  // One clock edge: drive at negedge, update model at posedge, return just after the edge
  task automatic step(input logic [4:0] w, input logic v, input logic c);
    @(negedge clk);
    rd_in = w; in_valid = v; clr_err = c;
    @(posedge clk);
    model_edge(int'(w), v, c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    #2 rst = 1'b1;
  endtask

  task automatic acquire();
    step(5'b00001, 1, 0);
    step(5'b00010, 1, 0);
    step(5'b00100, 1, 0);
    step(5'b01001, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; clr_err = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_in = 5'($urandom); in_valid = 1'($urandom); clr_err = 1'($urandom);
      #1;
      checks++;
      if (locked !== 1'b0 || err_tens !== 4'd0 || err_ones !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold %0d: got locked=%0b count=%0d%0d, want locked=0 count=00", i, locked, err_tens, err_ones);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(5'($urandom), 0, 0);
      checks++;
      if (locked !== 1'b0 || err_tens !== 4'd0 || err_ones !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle %0d: got locked=%0b count=%0d%0d, want locked=0 count=00", i, locked, err_tens, err_ones);
      end
    end
  endtask

  task automatic test_acquire();
    logic [4:0] words [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001};
    logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(words[i], 1, 0);
      checks++;
      if (locked !== exp_l[i] || locked !== m_locked || err_tens !== 4'd0 || err_ones !== 4'd0) begin
        errors++;
        $display("FAIL acquire edge %0d: got locked=%0b count=%0d%0d, want locked=%0b count=00", i + 1, locked, err_tens, err_ones, exp_l[i]);
      end
    end
  endtask

  task automatic test_single_error();
    logic [4:0] words [3] = '{5'b10011, 5'b00101, 5'b01011};
    do_reset();
    acquire();
    for (int i = 0; i < 3; i++) begin
      step(words[i], 1, 0);
      checks++;
      if (locked !== 1'b1 || err_tens !== 4'd0 || err_ones !== 4'd1 || m_cnt != 1) begin
        errors++;
        $display("FAIL single_error %0d: got locked=%0b count=%0d%0d, want locked=1 count=01", i, locked, err_tens, err_ones);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    logic [4:0] chain [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001};
    do_reset();
    acquire();
    for (int i = 0; i < 4; i++) begin
      step(5'(m_pred ^ 31), 1, 0);
      checks++;
      if (locked !== 1'(i < 3) || err_tens !== 4'd0 || err_ones !== 4'(i + 1)) begin
        errors++;
        $display("FAIL loss_of_lock miss %0d: got locked=%0b count=%0d%0d, want locked=%0b count=0%0d", i + 1, locked, err_tens, err_ones, i < 3, i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(chain[i], 1, 0);
      checks++;
      if (locked !== 1'(i == 3) || err_ones !== 4'd4 || err_tens !== 4'd0) begin
        errors++;
        $display("FAIL reseed edge %0d: got locked=%0b count=%0d%0d, want locked=%0b count=04", i + 1, locked, err_tens, err_ones, i == 3);
      end
    end
  endtask

  task automatic test_zero_word();
    logic [4:0] words [6] = '{5'b00000, 5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01001};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(words[i], 1, 0);
      checks++;
      if (locked !== 1'(i == 5) || locked !== m_locked) begin
        errors++;
        $display("FAIL zero_word edge %0d: got locked=%0b, want locked=%0b", i + 1, locked, i == 5);
      end
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    acquire();
    for (int i = 0; i < 140; i++) begin
      if (i % 4 == 3) step(5'(m_pred), 1, 0);
      else step(5'(m_pred ^ $urandom_range(1, 31)), 1, 0);
      checks++;
      if (locked !== m_locked || err_tens !== 4'(m_cnt / 10) || err_ones !== 4'(m_cnt % 10)) begin
        errors++;
        $display("FAIL saturate step %0d: got locked=%0b count=%0d%0d, want locked=%0b count=%0d", i, locked, err_tens, err_ones, m_locked, m_cnt);
      end
    end
    step(5'(m_pred), 1, 0);
    checks++;
    if (locked !== 1'b1 || err_tens !== 4'd9 || err_ones !== 4'd9) begin
      errors++;
      $display("FAIL saturate_99: got locked=%0b count=%0d%0d, want locked=1 count=99", locked, err_tens, err_ones);
    end
    step(5'(m_pred ^ 5'b00110), 1, 1);
    checks++;
    if (locked !== 1'b1 || err_tens !== 4'd0 || err_ones !== 4'd0) begin
      errors++;
      $display("FAIL clear_wins: got locked=%0b count=%0d%0d, want locked=1 count=00", locked, err_tens, err_ones);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    acquire();
    step(5'(m_pred ^ 5'b00001), 1, 0);
    #2;
    rst = 1'b0; in_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    #1;
    checks++;
    if (locked !== 1'b0 || err_tens !== 4'd0 || err_ones !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got locked=%0b count=%0d%0d, want locked=0 count=00", locked, err_tens, err_ones);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_locked) w = ($urandom_range(0, 99) < 85) ? 5'(m_pred) : 5'($urandom);
      else if ($urandom_range(0, 99) < 70 && m_seeded) w = 5'(m_pred);
      else if ($urandom_range(0, 99) < 10) w = 5'b00000;
      else w = 5'($urandom);
      step(w, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 39) == 0));
      checks++;
      if (locked !== m_locked || err_tens !== 4'(m_cnt / 10) || err_ones !== 4'(m_cnt % 10)) begin
        errors++;
        $display("FAIL random step %0d: got locked=%0b count=%0d%0d, want locked=%0b count=%0d", i, locked, err_tens, err_ones, m_locked, m_cnt);
      end
`ifdef LFSR_CHK_SEG_EN
      checks++;
      if (seg_ones !== seg_of(m_prev % 10) || seg_tens !== seg_of(m_prev / 10)) begin
        errors++;
        $display("FAIL random_seg step %0d: got %b %b, want %b %b", i, seg_tens, seg_ones, seg_of(m_prev / 10), seg_of(m_prev % 10));
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0; rd_in = '0; in_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_of_lock();
    test_zero_word();
    test_saturation_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
